motion_tick_engine: RTL and testbench
=====================================

Name: motion_tick_engine

Overview:
- Multi-channel motion timing block; the parametrised successor to the single-purpose alien-fall/shot rate dividers.
- A shared prescaler produces a base tick. Each of NUM_CH independent channels steps a position counter up or down every `period` base ticks, from a start position until it reaches a limit.
- Feeds the VGA draw control (step pulses), the game-over logic (done on alien channel) and shot collision logic (pos).

Parameters:
- CLOCK_FREQUENCY, 50000000: clk frequency in Hz.
- TICK_HZ, 60: base tick rate; TICK_DIV = CLOCK_FREQUENCY/TICK_HZ cycles per tick (integer, >=2).
- NUM_CH, 4: number of motion channels.
- POS_W, 7: position width.
- PERIOD_W, 8: per-channel period width, in base ticks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  NUM_CH  per-channel start pulse
- stop  in  NUM_CH  per-channel stop pulse
- dir  in  NUM_CH  0 = increment (falling), 1 = decrement (rising); sampled at start
- start_pos  in  NUM_CH*POS_W  initial position, channel c at [c*POS_W +: POS_W]
- limit  in  NUM_CH*POS_W  terminal position; sampled at start
- period  in  NUM_CH*PERIOD_W  base ticks per step; sampled at start; 0 treated as 1
- pos  out  NUM_CH*POS_W  current position per channel
- active  out  NUM_CH  channel running
- step  out  NUM_CH  1-cycle pulse, pos just changed
- done  out  NUM_CH  1-cycle pulse, channel reached limit
- base_tick  out  1  1-cycle prescaler pulse

Behaviour:
- Reset (sync, active-high, any cycle including mid-run):
  - prescaler count = 0; base_tick = 0.
  - All channels IDLE: pos = 0, active = 0, step = 0, done = 0, countdown = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - base_tick is registered, high for exactly one cycle per TICK_DIV cycles: the cycle after count == TICK_DIV-1.
  - Free-running; unaffected by channel state.
- Per-channel FSM, states IDLE and RUN:
  - start (either state): latch dir, limit, and effective period P = max(period, 1). Set pos = start_pos, countdown = P-1.
    - If start_pos == limit: stay/go IDLE; done = 1 next cycle; no step.
    - Otherwise: go RUN; active = 1 next cycle.
  - start and stop in the same cycle: start wins.
  - start while RUN restarts the channel cleanly. No done is raised for the aborted run.
  - stop in RUN: go IDLE, active = 0, pos holds, no step, no done. stop in IDLE is ignored.
  - RUN, base_tick = 1, countdown > 0: countdown decrements.
  - RUN, base_tick = 1, countdown == 0:
    - pos = pos+1 (dir = 0) or pos-1 (dir = 1), modulo 2^POS_W, so 0-1 wraps to 2^POS_W-1.
    - countdown = P-1; step = 1 in the cycle pos shows the new value.
    - If the new pos == limit: done = 1 in the same cycle as step, go IDLE, active = 0 that same cycle, pos holds at limit.
  - stop coinciding with a step edge: stop wins, no step, pos unchanged.
  - base_tick ignored in IDLE.
- Timing:
  - Step spacing is exactly P*TICK_DIV cycles.
  - First step occurs P base ticks after start: the first base_tick seen in RUN counts as 1. The start cycle itself does not count.
- Channels are fully independent; simultaneous events on different channels do not interact.
- step and done are never high for more than one consecutive cycle per event.
- A limit unreachable in the chosen direction is reached via wrap-around; no error is raised.

Test Plan:
All tests use CLOCK_FREQUENCY = 600, TICK_HZ = 60 (TICK_DIV = 10), NUM_CH = 4, POS_W = 7.
1. Reset/prescaler: hold reset 3 cycles, release -> all outputs 0; base_tick pulses every 10 cycles; reset asserted mid-run -> next cycle pos = 0, active = 0.
2. Falling channel: ch0 start, start_pos = 0, limit = 40, dir = 0, period = 4 -> step every 40 cycles, pos 1..40; done and step both high when pos = 40; active drops; 40 steps total.
3. Rising shot with wrap: ch1 start_pos = 2, limit = 125, dir = 1, period = 1 -> pos 1, 0, 127, 126, 125; done at 125 after 5 steps spaced 10 cycles.
4. Edge configs:
   - period = 0 behaves as period 1 (steps 10 cycles apart).
   - start_pos == limit -> done next cycle, no step, active stays 0.
5. Priority:
   - stop on the step edge -> no step, pos held, no done.
   - start + stop same cycle -> channel runs.
   - restart mid-run at start_pos = 10 -> pos = 10, no done pulse.
6. Concurrency: all 4 channels started the same cycle with periods 1, 2, 3, 4 -> independent step cadences (10/20/30/40 cycles); simultaneous done on ch0/ch1 both seen.

Source files
------------

// File: rtl/motion_tick_engine.sv
// -----------------------------------------------------------------------------
// motion_tick_engine
//
// Multi-channel motion timing block. A shared, free-running prescaler divides
// clk down to a base tick (TICK_DIV = CLOCK_FREQUENCY / TICK_HZ cycles). Each
// of NUM_CH independent channels steps a position counter up or down once
// every `period` base ticks, from a start position until it reaches a limit.
// Downstream users: VGA draw control (step), game-over logic (done on the
// alien channel), shot collision logic (pos).
//
// Ports:
//   clk        in   1                 system clock
//   reset      in   1                 synchronous, active-high reset
//   start      in   NUM_CH            per-channel start pulse (wins over stop)
//   stop       in   NUM_CH            per-channel stop pulse (ignored when idle)
//   dir        in   NUM_CH            0 = increment, 1 = decrement; sampled at start
//   start_pos  in   NUM_CH*POS_W      initial position, channel c at [c*POS_W +: POS_W]
//   limit      in   NUM_CH*POS_W      terminal position; sampled at start
//   period     in   NUM_CH*PERIOD_W   base ticks per step; sampled at start; 0 acts as 1
//   pos        out  NUM_CH*POS_W      current position per channel
//   active     out  NUM_CH            channel running
//   step       out  NUM_CH            1-cycle pulse, pos just changed
//   done       out  NUM_CH            1-cycle pulse, channel reached its limit
//   base_tick  out  1                 1-cycle prescaler pulse
// -----------------------------------------------------------------------------
module motion_tick_engine #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TICK_HZ         = 60,
  parameter int NUM_CH          = 4,
  parameter int POS_W           = 7,
  parameter int PERIOD_W        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            stop,
  input  logic [NUM_CH-1:0]            dir,
  input  logic [NUM_CH*POS_W-1:0]      start_pos,
  input  logic [NUM_CH*POS_W-1:0]      limit,
  input  logic [NUM_CH*PERIOD_W-1:0]   period,
  output logic [NUM_CH*POS_W-1:0]      pos,
  output logic [NUM_CH-1:0]            active,
  output logic [NUM_CH-1:0]            step,
  output logic [NUM_CH-1:0]            done,
  output logic                         base_tick
);

  localparam int TICK_DIV = CLOCK_FREQUENCY / TICK_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // ---------------------------------------------------------------------------
  // Prescaler: counts 0..TICK_DIV-1 and wraps. base_tick is registered, so it
  // is high in the cycle after the counter sits at its last value.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] presc_cnt_reg;
  logic             base_tick_reg;
  logic             presc_wrap;

  assign presc_wrap = (presc_cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_reg <= '0;
      base_tick_reg <= 1'b0;
    end else begin
      base_tick_reg <= presc_wrap;
      presc_cnt_reg <= presc_wrap ? '0 : presc_cnt_reg + CNT_W'(1);
    end
  end

  assign base_tick = base_tick_reg;

  // ---------------------------------------------------------------------------
  // Motion channels
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t           state_reg;
      logic                dir_reg;
      logic [POS_W-1:0]    pos_reg;
      logic [POS_W-1:0]    limit_reg;
      logic [PERIOD_W-1:0] reload_reg;     // effective period minus one
      logic [PERIOD_W-1:0] countdown_reg;
      logic                step_reg;
      logic                done_reg;

      logic [POS_W-1:0]    start_pos_in;
      logic [POS_W-1:0]    limit_in;
      logic [PERIOD_W-1:0] period_in;
      logic [PERIOD_W-1:0] reload_in;
      logic [POS_W-1:0]    pos_next;
      logic                step_due;

      assign start_pos_in = start_pos[gi*POS_W +: POS_W];
      assign limit_in     = limit[gi*POS_W +: POS_W];
      assign period_in    = period[gi*PERIOD_W +: PERIOD_W];

      // A period of 0 behaves like 1, and both reload the countdown with 0.
      assign reload_in = (period_in == '0) ? '0 : period_in - PERIOD_W'(1);

      // Modular step: natural wrap of the POS_W-bit adder gives 0-1 -> all ones.
      assign pos_next = dir_reg ? (pos_reg - POS_W'(1)) : (pos_reg + POS_W'(1));

      // The base tick that expires the countdown moves the channel.
      assign step_due = base_tick_reg && (countdown_reg == '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg     <= ST_IDLE;
          dir_reg       <= 1'b0;
          pos_reg       <= '0;
          limit_reg     <= '0;
          reload_reg    <= '0;
          countdown_reg <= '0;
          step_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end else begin
          // Pulses default low; each event below raises them for one cycle.
          step_reg <= 1'b0;
          done_reg <= 1'b0;

          if (start[gi]) begin
            // Start has top priority and also cleanly restarts a running
            // channel; the aborted run never reports done.
            dir_reg       <= dir[gi];
            limit_reg     <= limit_in;
            reload_reg    <= reload_in;
            countdown_reg <= reload_in;
            pos_reg       <= start_pos_in;
            if (start_pos_in == limit_in) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
            end
          end else begin
            case (state_reg)
              ST_RUN: begin
                if (stop[gi]) begin
                  // Stop also beats a coincident step: position holds.
                  state_reg <= ST_IDLE;
                end else if (base_tick_reg) begin
                  if (step_due) begin
                    pos_reg       <= pos_next;
                    countdown_reg <= reload_reg;
                    step_reg      <= 1'b1;
                    if (pos_next == limit_reg) begin
                      done_reg  <= 1'b1;
                      state_reg <= ST_IDLE;
                    end
                  end else begin
                    countdown_reg <= countdown_reg - PERIOD_W'(1);
                  end
                end
              end
              default: begin
                // Idle: base ticks and stop are ignored.
                state_reg <= ST_IDLE;
              end
            endcase
          end
        end
      end

      assign pos[gi*POS_W +: POS_W] = pos_reg;
      assign active[gi]             = (state_reg == ST_RUN);
      assign step[gi]               = step_reg;
      assign done[gi]               = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_motion_tick_engine.sv
module tb_motion_tick_engine;

  localparam int NCH  = 4;
  localparam int PW   = 7;
  localparam int PERW = 8;
  localparam int TDIV = 10;
  localparam int PMOD = 128;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       start, stop, dir;
  logic [NCH*PW-1:0]    start_pos, limit;
  logic [NCH*PERW-1:0]  period;
  logic [NCH*PW-1:0]    pos;
  logic [NCH-1:0]       active, step, done;
  logic                 base_tick;

  int checks   = 0;
  int failures = 0;

  motion_tick_engine #(
    .CLOCK_FREQUENCY(600),
    .TICK_HZ(60),
    .NUM_CH(NCH),
    .POS_W(PW),
    .PERIOD_W(PERW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .dir(dir),
    .start_pos(start_pos),
    .limit(limit),
    .period(period),
    .pos(pos),
    .active(active),
    .step(step),
    .done(done),
    .base_tick(base_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input int c);
    return int'(pos[c*PW +: PW]);
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: cycles since reset give the base tick; each channel
  // counts base ticks seen while running and moves when that count reaches P.
  // ---------------------------------------------------------------------------
  int m_cyc;
  bit m_bt;
  bit m_valid = 1'b0;
  bit m_run  [NCH];
  int m_pos  [NCH];
  bit m_dir  [NCH];
  int m_lim  [NCH];
  int m_P    [NCH];
  int m_seen [NCH];
  bit m_step [NCH];
  bit m_done [NCH];

  always @(posedge clk) begin : model_p
    bit tick_now;
    int delta;
    int per;
    tick_now = m_bt;
    if (reset) begin
      m_cyc   = 0;
      m_bt    = 1'b0;
      m_valid = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_pos[c] = 0; m_seen[c] = 0;
        m_step[c] = 0; m_done[c] = 0; m_dir[c] = 0; m_lim[c] = 0; m_P[c] = 1;
      end
    end else begin
      m_cyc = m_cyc + 1;
      m_bt  = (m_cyc % TDIV == 0);
      for (int c = 0; c < NCH; c++) begin
        m_step[c] = 0;
        m_done[c] = 0;
        if (start[c]) begin
          m_dir[c]  = dir[c];
          m_lim[c]  = int'(limit[c*PW +: PW]);
          per       = int'(period[c*PERW +: PERW]);
          m_P[c]    = (per == 0) ? 1 : per;
          m_pos[c]  = int'(start_pos[c*PW +: PW]);
          m_seen[c] = 0;
          if (m_pos[c] == m_lim[c]) begin
            m_run[c]  = 0;
            m_done[c] = 1;
          end else begin
            m_run[c] = 1;
          end
        end else if (m_run[c] && stop[c]) begin
          m_run[c] = 0;
        end else if (m_run[c] && tick_now) begin
          m_seen[c] = m_seen[c] + 1;
          if (m_seen[c] == m_P[c]) begin
            m_seen[c] = 0;
            delta     = m_dir[c] ? -1 : 1;
            m_pos[c]  = (m_pos[c] + delta + PMOD) % PMOD;
            m_step[c] = 1;
            if (m_pos[c] == m_lim[c]) begin
              m_done[c] = 1;
              m_run[c]  = 0;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin : compare_p
    logic [NCH*PW-1:0] e_pos;
    logic [NCH-1:0]    e_act, e_stp, e_dne;
    if (m_valid) begin
      for (int c = 0; c < NCH; c++) begin
        e_pos[c*PW +: PW] = PW'(m_pos[c]);
        e_act[c] = m_run[c];
        e_stp[c] = m_step[c];
        e_dne[c] = m_done[c];
      end
      check("cmp_base_tick", base_tick, m_bt);
      check("cmp_pos", pos, e_pos);
      check("cmp_active", active, e_act);
      check("cmp_step", step, e_stp);
      check("cmp_done", done, e_dne);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic cfg(input int c, input bit d, input int sp, input int lim, input int per);
    dir[c]                 = d;
    start_pos[c*PW +: PW]  = PW'(sp);
    limit[c*PW +: PW]      = PW'(lim);
    period[c*PERW +: PERW] = PERW'(per);
  endtask

  task automatic pulse_start(input logic [NCH-1:0] mask);
    start = mask;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_step(input int c, input int budget, output int dt);
    dt = 0;
    forever begin
      @(negedge clk);
      dt++;
      if (step[c]) begin
        $display("ch%0d step pos=%0d after %0d cycles", c, pos_of(c), dt);
        return;
      end
      if (dt >= budget) begin
        check("wait_step_timeout", dt, -1);
        return;
      end
    end
  endtask

  task automatic wait_bt(input int budget, output int dt);
    dt = 0;
    forever begin
      @(negedge clk);
      dt++;
      if (base_tick) return;
      if (dt >= budget) begin
        check("wait_bt_timeout", dt, -1);
        return;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int dt;
    int seq3 [5];
    int last [NCH];
    int nsteps [NCH];
    int cyc;
    bit simul_done;

    start = '0; stop = '0; dir = '0;
    start_pos = '0; limit = '0; period = '0;
    reset = 1'b1;

    // 1. Reset and prescaler
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pos", pos, 0);
    check("rst_active", active, 0);
    check("rst_step", step, 0);
    check("rst_done", done, 0);
    check("rst_base_tick", base_tick, 0);
    $display("reset released, outputs idle");
    wait_bt(20, dt);
    wait_bt(20, dt);
    check("bt_spacing_a", dt, 10);
    wait_bt(20, dt);
    check("bt_spacing_b", dt, 10);
    $display("base_tick spacing %0d cycles", dt);

    cfg(2, 0, 5, 100, 1);
    pulse_start(4'b0100);
    wait_step(2, 30, dt);
    check("midrun_pos_before", pos_of(2), 6);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_rst_pos", pos_of(2), 0);
    check("midrun_rst_active", active[2], 0);
    reset = 1'b0;
    $display("mid-run reset cleared channel 2");

    // 2. Falling channel: 0 -> 40, period 4
    cfg(0, 0, 0, 40, 4);
    pulse_start(4'b0001);
    check("fall_active", active[0], 1);
    for (int k = 1; k <= 40; k++) begin
      wait_step(0, 60, dt);
      check("fall_pos", pos_of(0), k);
      if (k > 1) check("fall_spacing", dt, 40);
      check("fall_done", done[0], (k == 40) ? 1 : 0);
      check("fall_active_run", active[0], (k == 40) ? 0 : 1);
    end
    @(negedge clk);
    check("fall_done_pulse", done[0], 0);
    check("fall_step_pulse", step[0], 0);
    check("fall_pos_hold", pos_of(0), 40);

    // 3. Rising shot with wrap: 2 -> 125 downward
    seq3 = '{1, 0, 127, 126, 125};
    cfg(1, 1, 2, 125, 1);
    pulse_start(4'b0010);
    for (int k = 0; k < 5; k++) begin
      wait_step(1, 30, dt);
      check("wrap_pos", pos_of(1), seq3[k]);
      if (k > 0) check("wrap_spacing", dt, 10);
      check("wrap_done", done[1], (k == 4) ? 1 : 0);
    end
    @(negedge clk);
    check("wrap_idle", active[1], 0);

    // 4a. period 0 behaves as 1
    cfg(2, 0, 0, 3, 0);
    pulse_start(4'b0100);
    for (int k = 1; k <= 3; k++) begin
      wait_step(2, 30, dt);
      check("p0_pos", pos_of(2), k);
      if (k > 1) check("p0_spacing", dt, 10);
    end
    check("p0_done", done[2], 1);

    // 4b. start_pos == limit: immediate done, no step
    cfg(3, 0, 7, 7, 5);
    pulse_start(4'b1000);
    check("eq_done", done[3], 1);
    check("eq_step", step[3], 0);
    check("eq_active", active[3], 0);
    check("eq_pos", pos_of(3), 7);
    @(negedge clk);
    check("eq_done_pulse", done[3], 0);
    $display("start_pos==limit gave immediate done");

    // 5a. stop on the step edge
    cfg(0, 0, 0, 50, 1);
    pulse_start(4'b0001);
    wait_step(0, 30, dt);
    check("stopedge_pos1", pos_of(0), 1);
    repeat (9) @(negedge clk);
    stop = 4'b0001;
    @(negedge clk);
    stop = '0;
    check("stopedge_step", step[0], 0);
    check("stopedge_pos", pos_of(0), 1);
    check("stopedge_active", active[0], 0);
    check("stopedge_done", done[0], 0);
    repeat (25) @(negedge clk);
    check("stopedge_hold", pos_of(0), 1);
    $display("stop on step edge held pos=%0d", pos_of(0));

    // 5b. start + stop together: start wins
    cfg(1, 0, 0, 20, 1);
    start = 4'b0010;
    stop  = 4'b0010;
    @(negedge clk);
    start = '0;
    stop  = '0;
    check("startstop_active", active[1], 1);

    // 5c. restart mid-run at 10
    wait_step(1, 30, dt);
    check("restart_pre", pos_of(1), 1);
    cfg(1, 0, 10, 20, 1);
    pulse_start(4'b0010);
    check("restart_pos", pos_of(1), 10);
    check("restart_done", done[1], 0);
    check("restart_active", active[1], 1);
    wait_step(1, 30, dt);
    check("restart_next", pos_of(1), 11);
    stop = 4'b0010;
    @(negedge clk);
    stop = '0;
    check("restart_stopped", active[1], 0);
    $display("restart mid-run resumed from 10");

    // 6. Concurrency: periods 1..4, ch0/ch1 finish together
    cfg(0, 0, 0, 4, 1);
    cfg(1, 0, 0, 2, 2);
    cfg(2, 0, 0, 5, 3);
    cfg(3, 0, 0, 5, 4);
    pulse_start(4'hF);
    check("conc_active", active, 4'hF);
    for (int c = 0; c < NCH; c++) begin
      last[c] = -1;
      nsteps[c] = 0;
    end
    simul_done = 0;
    cyc = 0;
    repeat (230) begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        if (step[c]) begin
          if (last[c] >= 0) check("conc_spacing", cyc - last[c], 10 * (c + 1));
          last[c] = cyc;
          nsteps[c]++;
          $display("ch%0d step pos=%0d at cycle %0d", c, pos_of(c), cyc);
        end
      end
      if (done[0]) begin
        check("conc_simul_done", done[1], 1);
        simul_done = 1;
      end
    end
    check("conc_simul_seen", simul_done, 1);
    check("conc_steps0", nsteps[0], 4);
    check("conc_steps1", nsteps[1], 2);
    check("conc_steps2", nsteps[2], 5);
    check("conc_steps3", nsteps[3], 5);
    check("conc_idle", active, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
